// File: rtl/rv_pkg.sv
// Shared definitions for the register-file writeback path.
//   XLEN        default datapath width
//   REG_ADDR_W  register address width
//   REG_ZERO    address of the hard-wired zero register
//   wb_req_e    writeback requester index, also the fixed priority order (lowest wins)
//   pick_first  one-hot of the lowest-index set request bit
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam int unsigned NUM_REQ    = 3;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_MDU = 2'd2
  } wb_req_e;

  // Isolate the lowest set bit; index order is the priority order.
  function automatic logic [NUM_REQ-1:0] pick_first(input logic [NUM_REQ-1:0] req);
    return req & (~req + 3'd1);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard for pending register-file writes.
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_issue_*               decode-side instruction being presented
//   i_clr_valid, i_clr_rd   writeback granted this cycle for register i_clr_rd
//   o_issue_stall           RAW/WAW hazard against a pending write (combinational)
module rf_scoreboard (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_issue_valid,
  input  logic [4:0] i_issue_rs1,
  input  logic [4:0] i_issue_rs2,
  input  logic [4:0] i_issue_rd,
  input  logic       i_issue_rd_wen,
  input  logic       i_clr_valid,
  input  logic [4:0] i_clr_rd,
  output logic       o_issue_stall
);
  import rv_pkg::*;

  logic [31:0] r_busy;
  logic [31:0] w_busy_d;
  logic        w_set;

  assign o_issue_stall = i_issue_valid &
                         (r_busy[i_issue_rs1] | r_busy[i_issue_rs2] |
                          (i_issue_rd_wen & r_busy[i_issue_rd]));

  assign w_set = i_issue_valid & ~o_issue_stall & i_issue_rd_wen & (i_issue_rd != REG_ZERO);

  always_comb begin
    w_busy_d = r_busy;
    if (i_clr_valid) w_busy_d[i_clr_rd] = 1'b0;
    // Applied after the clear: the newly issued producer owns rd.
    if (w_set) w_busy_d[i_issue_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: arbitrates writeback among MEM, ALU and MDU with
// anti-starvation promotion, registers the winning write, and stalls issue on hazards.
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_issue_* / o_issue_stall          decode hazard interface (stall is combinational)
//   i_{mem,alu,mdu}_valid/_rd/_data    writeback requests, held until ready
//   o_{mem,alu,mdu}_ready              grant, combinational, at most one per cycle
//   o_reg_write, o_wb_rd, o_wb_data    registered write port to the register file
module rf_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rs1,
  input  logic [4:0]      i_issue_rs2,
  input  logic [4:0]      i_issue_rd,
  input  logic            i_issue_rd_wen,
  output logic            o_issue_stall,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  output logic            o_alu_ready,
  input  logic            i_mem_valid,
  input  logic [4:0]      i_mem_rd,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_mem_ready,
  input  logic            i_mdu_valid,
  input  logic [4:0]      i_mdu_rd,
  input  logic [XLEN-1:0] i_mdu_data,
  output logic            o_mdu_ready,
  output logic            o_reg_write,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data
);
  import rv_pkg::*;

  localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

  logic [NUM_REQ-1:0] w_valid;
  logic [4:0]         w_rd   [NUM_REQ];
  logic [XLEN-1:0]    w_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_starved;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_any;
  logic [4:0]         w_gnt_rd;
  logic [XLEN-1:0]    w_gnt_data;

  logic [2:0]         r_starve [NUM_REQ];
  logic               r_reg_write;
  logic [4:0]         r_wb_rd;
  logic [XLEN-1:0]    r_wb_data;

  assign w_valid[WB_MEM] = i_mem_valid;
  assign w_valid[WB_ALU] = i_alu_valid;
  assign w_valid[WB_MDU] = i_mdu_valid;
  assign w_rd[WB_MEM]    = i_mem_rd;
  assign w_rd[WB_ALU]    = i_alu_rd;
  assign w_rd[WB_MDU]    = i_mdu_rd;
  assign w_data[WB_MEM]  = i_mem_data;
  assign w_data[WB_ALU]  = i_alu_data;
  assign w_data[WB_MDU]  = i_mdu_data;

  always_comb begin
    w_gnt      = '0;
    w_gnt_rd   = REG_ZERO;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_starved[i] = w_valid[i] & (r_starve[i] == StarveMax);
    end
    // No grants during reset so nothing is handed over that the registers would drop.
    if (!i_rst) begin
      if (|w_starved) w_gnt = pick_first(w_starved);
      else            w_gnt = pick_first(w_valid);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_rd   = w_rd[i];
        w_gnt_data = w_data[i];
      end
    end
  end

  assign w_gnt_any   = |w_gnt;
  assign o_mem_ready = w_gnt[WB_MEM];
  assign o_alu_ready = w_gnt[WB_ALU];
  assign o_mdu_ready = w_gnt[WB_MDU];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reg_write <= 1'b0;
      r_wb_rd     <= REG_ZERO;
      r_wb_data   <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_starve[i] <= 3'd0;
    end else begin
      // x0 grants complete the handshake but never reach the register file.
      r_reg_write <= w_gnt_any & (w_gnt_rd != REG_ZERO);
      if (w_gnt_any) begin
        r_wb_rd   <= w_gnt_rd;
        r_wb_data <= w_gnt_data;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt[i] || !w_valid[i]) r_starve[i] <= 3'd0;
        else if (r_starve[i] < StarveMax) r_starve[i] <= r_starve[i] + 3'd1;
      end
    end
  end

  assign o_reg_write = r_reg_write;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;

  rf_scoreboard u_scoreboard (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue_valid (i_issue_valid),
    .i_issue_rs1   (i_issue_rs1),
    .i_issue_rs2   (i_issue_rs2),
    .i_issue_rd    (i_issue_rd),
    .i_issue_rd_wen(i_issue_rd_wen),
    .i_clr_valid   (w_gnt_any),
    .i_clr_rd      (w_gnt_rd),
    .o_issue_stall (o_issue_stall)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a behavioural model of grants, starvation, scoreboard and outputs.
module tb_rf_wb_arbiter;

  localparam int SM = 4;
  localparam int MEM = 0, ALU = 1, MDU = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_rd_wen;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        p_valid [3];
  logic [4:0]  p_rd    [3];
  logic [31:0] p_data  [3];
  logic        alu_ready, mem_ready, mdu_ready;
  logic        reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Reference model state
  bit [31:0]   m_busy;
  int          m_cnt [3];
  bit          m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(32), .STARVE_MAX(SM)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_issue_valid (issue_valid),
    .i_issue_rs1   (issue_rs1),
    .i_issue_rs2   (issue_rs2),
    .i_issue_rd    (issue_rd),
    .i_issue_rd_wen(issue_rd_wen),
    .o_issue_stall (issue_stall),
    .i_alu_valid   (p_valid[ALU]),
    .i_alu_rd      (p_rd[ALU]),
    .i_alu_data    (p_data[ALU]),
    .o_alu_ready   (alu_ready),
    .i_mem_valid   (p_valid[MEM]),
    .i_mem_rd      (p_rd[MEM]),
    .i_mem_data    (p_data[MEM]),
    .o_mem_ready   (mem_ready),
    .i_mdu_valid   (p_valid[MDU]),
    .i_mdu_rd      (p_rd[MDU]),
    .i_mdu_data    (p_data[MDU]),
    .o_mdu_ready   (mdu_ready),
    .o_reg_write   (reg_write),
    .o_wb_rd       (wb_rd),
    .o_wb_data     (wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner by rule: starved requesters first, then plain priority, order MEM, ALU, MDU.
  function automatic int exp_grant();
    if (rst) return -1;
    for (int i = 0; i < 3; i++) if (p_valid[i] && m_cnt[i] == SM) return i;
    for (int i = 0; i < 3; i++) if (p_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit exp_stall();
    return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                           (issue_rd_wen && m_busy[issue_rd]));
  endfunction

  // One clock: compare at negedge, advance the model at posedge, retire the granted request.
  task automatic cycle(output int g);
    bit         st;
    logic [2:0] exp_rdy;
    @(negedge clk);
    g  = exp_grant();
    st = exp_stall();
    exp_rdy = 3'b000;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ready", {29'b0, mdu_ready, alu_ready, mem_ready}, {29'b0, exp_rdy});
    check("issue_stall", {31'b0, issue_stall}, {31'b0, st});
    check("reg_write", {31'b0, reg_write}, {31'b0, m_rw});
    check("wb_rd", {27'b0, wb_rd}, {27'b0, m_rd});
    check("wb_data", wb_data, m_data);
    @(posedge clk);
    if (rst) begin
      m_busy = '0; m_rw = 0; m_rd = '0; m_data = '0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      m_rw = (g >= 0) && (p_rd[g] != 0);
      if (g >= 0) begin
        m_rd   = p_rd[g];
        m_data = p_data[g];
        m_busy[p_rd[g]] = 1'b0;
      end
      if (issue_valid && !st && issue_rd_wen && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (g == i || !p_valid[i]) m_cnt[i] = 0;
        else if (m_cnt[i] < SM)    m_cnt[i] = m_cnt[i] + 1;
      end
    end
    #1;
    if (g >= 0) p_valid[g] = 1'b0;
  endtask

  task automatic raise(input int i, input logic [4:0] rd, input logic [31:0] data);
    p_valid[i] = 1'b1;
    p_rd[i]    = rd;
    p_data[i]  = data;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wen);
    issue_valid  = v;
    issue_rs1    = rs1;
    issue_rs2    = rs2;
    issue_rd     = rd;
    issue_rd_wen = wen;
  endtask

  initial begin
    int          g;
    int          n;
    int          order [$];
    logic [31:0] probe;

    m_busy = '0; m_rw = 0; m_rd = '0; m_data = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;

    // Reset with every requester asserting valid
    rst = 1'b1;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    raise(MEM, 5'd1, 32'h11); raise(ALU, 5'd2, 32'h22); raise(MDU, 5'd3, 32'h33);
    @(posedge clk); #1;
    cycle(g);
    cycle(g);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) p_valid[i] = 1'b0;

    // No register may look busy after reset
    probe = '0;
    for (int r = 1; r < 32; r++) begin
      set_issue(1'b1, 5'(r), 5'd0, 5'd0, 1'b0);
      #1 probe[r] = issue_stall;
      cycle(g);
    end
    check("busy_after_reset", probe, 32'h0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Single ALU write
    raise(ALU, 5'd1, 32'h1);
    #1 check("alu_single_ready", {31'b0, alu_ready}, 32'd1);
    cycle(g);
    check("alu_single_we", {31'b0, reg_write}, 32'd1);
    check("alu_single_rd", {27'b0, wb_rd}, 32'd1);
    check("alu_single_data", wb_data, 32'h1);
    cycle(g);

    // Three-way contention
    raise(MEM, 5'd5, 32'h5); raise(ALU, 5'd6, 32'h6); raise(MDU, 5'd7, 32'h7);
    order.delete();
    for (int c = 0; c < 3; c++) begin
      cycle(g);
      order.push_back(g);
      check("contention_wb_rd", {27'b0, wb_rd}, 32'd5 + 32'(c));
    end
    check("contention_order0", 32'(order[0]), MEM);
    check("contention_order1", 32'(order[1]), ALU);
    check("contention_order2", 32'(order[2]), MDU);
    cycle(g);

    // Starvation: MEM and ALU keep requesting, MDU must still get through
    raise(MDU, 5'd9, 32'h99);
    n = -1;
    for (int c = 0; c < 12; c++) begin
      if (!p_valid[MEM]) raise(MEM, 5'($urandom_range(10, 20)), $urandom);
      if (!p_valid[ALU]) raise(ALU, 5'($urandom_range(21, 31)), $urandom);
      cycle(g);
      if (g == MDU) begin
        n = c;
        break;
      end
    end
    check("mdu_starve_bound", {31'b0, (n >= 0 && n <= SM + 1)}, 32'd1);
    p_valid[MEM] = 1'b0; p_valid[ALU] = 1'b0; p_valid[MDU] = 1'b0;
    cycle(g);
    cycle(g);

    // RAW hazard on x5 until the cycle after its writeback grant
    set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    cycle(g);
    set_issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    #1 check("raw_stall", {31'b0, issue_stall}, 32'd1);
    cycle(g);
    check("raw_stall_hold", {31'b0, issue_stall}, 32'd1);
    raise(MEM, 5'd5, 32'h55);
    cycle(g);
    check("raw_release", {31'b0, issue_stall}, 32'd0);
    set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    cycle(g);
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1 check("x0_no_stall", {31'b0, issue_stall}, 32'd0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    raise(MEM, 5'd5, 32'h505);
    cycle(g);

    // Same-cycle set and clear of x3: set wins
    set_issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    raise(MEM, 5'd3, 32'h33);
    cycle(g);
    set_issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
    #1 check("set_wins_busy3", {31'b0, issue_stall}, 32'd1);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    raise(MEM, 5'd3, 32'h333);
    cycle(g);

    // rd = x0: handshake completes, nothing written
    raise(ALU, 5'd0, 32'hdead_beef);
    #1 check("x0_ready", {31'b0, alu_ready}, 32'd1);
    cycle(g);
    check("x0_no_write", {31'b0, reg_write}, 32'd0);
    cycle(g);

    // Random traffic, including resets with requests in flight
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 3; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1)
          raise(i, 5'($urandom_range(0, 7)), $urandom);
      end
      cycle(g);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
